// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Purpose : 8N1 UART receiver with oversampled start/bit detection feeding a
//           small byte FIFO with overflow and framing-error reporting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
   parameter int SAMPLE_MULTIPLIER = 8,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clken,
   input  logic                          rx,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          frame_err,
   output logic                          overflow,
   input  logic                          clr_err
);

   localparam int CNT_W = $clog2(SAMPLE_MULTIPLIER);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(SAMPLE_MULTIPLIER / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_MULTIPLIER - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic             rx_meta_q, rx_s_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bitpos_q, bitpos_d;
   logic [7:0]       shift_q, shift_d;
   logic             armed_q, armed_d;
   logic             frame_err_q, frame_err_d;
   logic             push;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             overflow_q, overflow_d;
   logic             pop, full, wr_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Receiver state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bitpos_q    <= '0;
         shift_q     <= '0;
         armed_q     <= 1'b1;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitpos_q    <= bitpos_d;
         shift_q     <= shift_d;
         armed_q     <= armed_d;
         frame_err_q <= frame_err_d;
      end
   end

   // armed_q blocks a new start until the line has been seen high after a framing error
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitpos_d = bitpos_q;
      shift_d  = shift_q;
      armed_d  = armed_q;
      if (clken) begin
         case (state_q)
            S_IDLE: begin
               if (rx_s_q) begin
                  armed_d = 1'b1;
               end else if (armed_q) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end
            end
            S_START: begin
               if (cnt_q == MID_CNT) begin
                  cnt_d = '0;
                  if (!rx_s_q) begin
                     state_d  = S_DATA;
                     bitpos_d = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (cnt_q == LAST_CNT) begin
                  shift_d[bitpos_q] = rx_s_q;
                  cnt_d             = '0;
                  if (bitpos_q == 3'd7) begin
                     state_d = S_STOP;
                  end else begin
                     bitpos_d = bitpos_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               if (cnt_q == LAST_CNT) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  if (!rx_s_q) begin
                     armed_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_comb begin
      push        = 1'b0;
      frame_err_d = 1'b0;
      if (clken && (state_q == S_STOP) && (cnt_q == LAST_CNT)) begin
         push        = rx_s_q;
         frame_err_d = !rx_s_q;
      end
   end

   assign frame_err = frame_err_q;

   // A pop frees a slot in the same cycle, so push into a full FIFO is legal then
   assign rd_valid = (level_q != '0);
   assign pop      = rd_valid & rd_ready;
   assign full     = (level_q == FULL_LVL);
   assign wr_en    = push & (!full | pop);

   always_comb begin
      wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d    = level_q;
      case ({wr_en, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      overflow_d = overflow_q;
      if (push && full && !pop) begin
         overflow_d = 1'b1;
      end else if (clr_err) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= shift_q;
      end
   end

   assign rd_data  = mem[rd_ptr_q];
   assign level    = level_q;
   assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module  : tb_uart_rx_fifo
// Purpose : Directed self-checking bench for uart_rx_fifo (8x oversampling,
//           clken every 4th clk, 32 clk per bit).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       clken;
   logic       rx;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [2:0] level;
   logic       frame_err;
   logic       overflow;
   logic       clr_err;

   int n_pass  = 0;
   int n_total = 0;
   int fe_cnt  = 0;
   int fe_base;
   bit pushpop_seen;

   uart_rx_fifo #(.SAMPLE_MULTIPLIER(8), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .clken     (clken),
      .rx        (rx),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .level     (level),
      .frame_err (frame_err),
      .overflow  (overflow),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   initial begin
      int ph;
      ph    = 0;
      clken = 1'b0;
      forever begin
         @(negedge clk);
         ph    = (ph + 1) % 4;
         clken = (ph == 0);
      end
   end

   always @(posedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends one frame; with pop_on_push the consumer accepts on exactly the push cycle
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit pop_on_push);
      rx = 1'b0;
      wait_clks(32);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(32);
      end
      rx = stop_bit;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (pop_on_push) begin
            #1;
            rd_ready = dut.push;
            if (dut.push === 1'b1) pushpop_seen = 1'b1;
         end
      end
      rx = 1'b1;
      if (pop_on_push) rd_ready = 1'b0;
   endtask

   task automatic pop_one();
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1; rd_ready = 1'b0; clr_err = 1'b0;
      wait_clks(4);
      n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
      n_total++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
      n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
      rst = 1'b0;
      wait_clks(40);
   endtask

   task automatic test_basic();
      fe_base = fe_cnt;
      send_byte(8'hA5, 1'b1, 1'b0);
      wait_clks(8);
      n_total++; if (rd_valid !== 1'b1) $display("FAIL basic_rd_valid: got %b want 1", rd_valid); else n_pass++;
      n_total++; if (rd_data !== 8'hA5) $display("FAIL basic_rd_data: got %h want a5", rd_data); else n_pass++;
      n_total++; if (level !== 3'd1) $display("FAIL basic_level: got %0d want 1", level); else n_pass++;
      n_total++; if (fe_cnt - fe_base != 0) $display("FAIL basic_frame_err: got %0d pulses want 0", fe_cnt - fe_base); else n_pass++;
      wait_clks(20);
      n_total++; if (rd_data !== 8'hA5) $display("FAIL basic_hold: got %h want a5", rd_data); else n_pass++;
      pop_one();
      n_total++; if (rd_valid !== 1'b0) $display("FAIL basic_pop_valid: got %b want 0", rd_valid); else n_pass++;
      n_total++; if (level !== 3'd0) $display("FAIL basic_pop_level: got %0d want 0", level); else n_pass++;
   endtask

   task automatic test_glitch();
      fe_base = fe_cnt;
      rx = 1'b0;
      wait_clks(8);
      rx = 1'b1;
      wait_clks(400);
      n_total++; if (level !== 3'd0) $display("FAIL glitch_level: got %0d want 0", level); else n_pass++;
      n_total++; if (fe_cnt - fe_base != 0) $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - fe_base); else n_pass++;
      send_byte(8'h96, 1'b1, 1'b0);
      wait_clks(8);
      n_total++; if (rd_data !== 8'h96 || level !== 3'd1) $display("FAIL glitch_recover: got %h/%0d want 96/1", rd_data, level); else n_pass++;
      pop_one();
   endtask

   task automatic test_frame_err();
      fe_base = fe_cnt;
      send_byte(8'h3C, 1'b0, 1'b0);
      wait_clks(40);
      n_total++; if (fe_cnt - fe_base != 1) $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe_base); else n_pass++;
      n_total++; if (level !== 3'd0) $display("FAIL ferr_level: got %0d want 0", level); else n_pass++;
      send_byte(8'h41, 1'b1, 1'b0);
      wait_clks(8);
      n_total++; if (rd_data !== 8'h41) $display("FAIL ferr_next_data: got %h want 41", rd_data); else n_pass++;
      n_total++; if (level !== 3'd1) $display("FAIL ferr_next_level: got %0d want 1", level); else n_pass++;
      pop_one();
   endtask

   task automatic test_break_guard();
      fe_base = fe_cnt;
      rx = 1'b0;
      wait_clks(32 * 20);
      rx = 1'b1;
      wait_clks(64);
      n_total++; if (fe_cnt - fe_base != 1) $display("FAIL guard_pulses: got %0d want 1", fe_cnt - fe_base); else n_pass++;
      n_total++; if (level !== 3'd0) $display("FAIL guard_level: got %0d want 0", level); else n_pass++;
      send_byte(8'hC3, 1'b1, 1'b0);
      wait_clks(8);
      n_total++; if (rd_data !== 8'hC3) $display("FAIL guard_recover: got %h want c3", rd_data); else n_pass++;
      pop_one();
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      fe_base = fe_cnt;
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
      wait_clks(8);
      n_total++; if (level !== 3'd4) $display("FAIL ovf_level: got %0d want 4", level); else n_pass++;
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
      n_total++; if (fe_cnt - fe_base != 0) $display("FAIL ovf_frame_err: got %0d want 0", fe_cnt - fe_base); else n_pass++;
      for (int i = 1; i <= 4; i++) begin
         exp = 8'(i);
         n_total++; if (rd_data !== exp) $display("FAIL ovf_pop%0d: got %h want %h", i, rd_data, exp); else n_pass++;
         pop_one();
      end
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
      n_total++; if (rd_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", rd_valid); else n_pass++;
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
   endtask

   task automatic test_full_pushpop();
      logic [7:0] exp_q [$];
      exp_q = '{8'h20, 8'h30, 8'h40, 8'h77};
      send_byte(8'h10, 1'b1, 1'b0);
      send_byte(8'h20, 1'b1, 1'b0);
      send_byte(8'h30, 1'b1, 1'b0);
      send_byte(8'h40, 1'b1, 1'b0);
      wait_clks(4);
      n_total++; if (level !== 3'd4) $display("FAIL full_pre_level: got %0d want 4", level); else n_pass++;
      pushpop_seen = 1'b0;
      send_byte(8'h77, 1'b1, 1'b1);
      wait_clks(4);
      n_total++; if (pushpop_seen !== 1'b1) $display("FAIL full_push_seen: got %b want 1", pushpop_seen); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL full_overflow: got %b want 0", overflow); else n_pass++;
      n_total++; if (level !== 3'd4) $display("FAIL full_level: got %0d want 4", level); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++; if (rd_data !== exp_q[i]) $display("FAIL full_pop%0d: got %h want %h", i, rd_data, exp_q[i]); else n_pass++;
         pop_one();
      end
      n_total++; if (level !== 3'd0) $display("FAIL full_drained: got %0d want 0", level); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      rx = 1'b0;
      wait_clks(32);
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         wait_clks(32);
      end
      wait_clks(16);
      rst = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(32 * 7);
      n_total++; if (level !== 3'd0) $display("FAIL rstmid_level: got %0d want 0", level); else n_pass++;
      n_total++; if (rd_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", rd_valid); else n_pass++;
      send_byte(8'h5A, 1'b1, 1'b0);
      wait_clks(8);
      n_total++; if (rd_data !== 8'h5A) $display("FAIL rstmid_data: got %h want 5a", rd_data); else n_pass++;
      n_total++; if (level !== 3'd1) $display("FAIL rstmid_next_level: got %0d want 1", level); else n_pass++;
      pop_one();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_break_guard();
      test_overflow();
      test_full_pushpop();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
